// File: rtl/ram_share_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_share_arb_pkg
// Description : Shared sizes, requester ids and read-tag type for ram_share_arb
// Revision    : 1.0  initial release
// ============================================================================
package ram_share_arb_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // Read-return tag: which requester the next ram_q belongs to
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage : ram_share_arb_pkg
`default_nettype wire

// File: rtl/ram_share_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_share_arb_if
// Description : One requester port of the shared-RAM arbiter (req/gnt + read return)
// Revision    : 1.0  initial release
// ============================================================================
interface ram_share_arb_if
    import ram_share_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface : ram_share_arb_if
`default_nettype wire

// File: rtl/ram_share_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ram_share_arb_rr_arb2
// Description : Two-input round-robin grant with owner lock for atomic sequences
// Revision    : 1.0  initial release
// ============================================================================
module ram_share_arb_rr_arb2
    import ram_share_arb_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic a_req,
    input  wire logic a_lock,
    input  wire logic b_req,
    input  wire logic b_lock,
    output logic      a_gnt,
    output logic      b_gnt
);

    req_id_t r_last;
    req_id_t r_owner;
    logic    r_locked;

    logic    w_owner_req;
    logic    w_hold;

    // Lock only bites while its owner is still requesting; a dropped req frees the RAM this cycle
    assign w_owner_req = (r_owner == REQ_A) ? a_req : b_req;
    assign w_hold      = r_locked && w_owner_req;

    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst_n) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end else if (w_hold) begin
            a_gnt = (r_owner == REQ_A);
            b_gnt = (r_owner == REQ_B);
        end else if (a_req && b_req) begin
            a_gnt = (r_last == REQ_B);
            b_gnt = (r_last == REQ_A);
        end else begin
            a_gnt = a_req;
            b_gnt = b_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last   <= REQ_B;
            r_owner  <= REQ_A;
            r_locked <= 1'b0;
        end else if (a_gnt || b_gnt) begin
            r_last   <= a_gnt ? REQ_A : REQ_B;
            r_owner  <= a_gnt ? REQ_A : REQ_B;
            r_locked <= a_gnt ? a_lock : b_lock;
        end else begin
            r_locked <= 1'b0;
        end
    end

endmodule : ram_share_arb_rr_arb2
`default_nettype wire

// File: rtl/ram_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : ram_share_arb
// Description : Time-shares one single-port sync RAM between two requesters
// Revision    : 1.0  initial release
// ============================================================================
module ram_share_arb
    import ram_share_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    ram_share_arb_if.slave     a,
    ram_share_arb_if.slave     b,
    output logic [AW-1:0]      ram_a,
    output logic [DW-1:0]      ram_d,
    output logic               ram_we,
    input  wire logic [DW-1:0] ram_q
);

    logic    w_a_gnt;
    logic    w_b_gnt;
    logic    w_rd_acc;
    rd_tag_t r_tag;

    ram_share_arb_rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .a_req  (a.req),
        .a_lock (a.lock),
        .b_req  (b.req),
        .b_lock (b.lock),
        .a_gnt  (w_a_gnt),
        .b_gnt  (w_b_gnt)
    );

    assign a.gnt = w_a_gnt;
    assign b.gnt = w_b_gnt;

    // Idle cycles park the RAM pins at zero so nothing stale reaches the macro
    always_comb begin
        ram_we = 1'b0;
        ram_a  = '0;
        ram_d  = '0;
        if (w_a_gnt) begin
            ram_we = a.we;
            ram_a  = a.addr;
            ram_d  = a.wdata;
        end else if (w_b_gnt) begin
            ram_we = b.we;
            ram_a  = b.addr;
            ram_d  = b.wdata;
        end
    end

    assign w_rd_acc = (w_a_gnt && !a.we) || (w_b_gnt && !b.we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag <= '0;
        end else begin
            r_tag.valid <= w_rd_acc;
            r_tag.id    <= w_b_gnt ? REQ_B : REQ_A;
        end
    end

    assign a.rvalid = r_tag.valid && (r_tag.id == REQ_A);
    assign b.rvalid = r_tag.valid && (r_tag.id == REQ_B);
    assign a.rdata  = ram_q;
    assign b.rdata  = ram_q;

endmodule : ram_share_arb
`default_nettype wire

// File: tb/tb_ram_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_share_arb
// Description : Directed vector table plus randomized traffic against a reference model
// Revision    : 1.0  initial release
// ============================================================================
module tb_ram_share_arb;
    import ram_share_arb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    ram_share_arb_if #(.AW(AW), .DW(DW)) a_if ();
    ram_share_arb_if #(.AW(AW), .DW(DW)) b_if ();

    ram_share_arb #(.AW(AW), .DW(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a_if),
        .b      (b_if),
        .ram_a  (ram_a),
        .ram_d  (ram_d),
        .ram_we (ram_we),
        .ram_q  (ram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM: registered read, old data on read-during-write
    logic [DW-1:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'(i * i);
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_d;
        ram_q <= mem[ram_a];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: requester ids 0=A 1=B, -1 = nobody
    int            m_last;
    int            m_own;
    int            m_pend;
    logic [DW-1:0] m_pdata;
    logic [DW-1:0] shadow [16];
    int            m_g;
    bit            c_req [2];
    bit            c_we  [2];
    bit            c_lock[2];
    int            c_addr[2];
    logic [DW-1:0] c_wd  [2];

    task automatic model_reset();
        m_last = 1;
        m_own  = -1;
        m_pend = -1;
    endtask

    task automatic model_eval();
        c_req[0] = a_if.req;  c_we[0] = a_if.we;  c_lock[0] = a_if.lock;
        c_addr[0] = int'(a_if.addr); c_wd[0] = a_if.wdata;
        c_req[1] = b_if.req;  c_we[1] = b_if.we;  c_lock[1] = b_if.lock;
        c_addr[1] = int'(b_if.addr); c_wd[1] = b_if.wdata;
        m_g = -1;
        if (rst_n) begin
            if (m_own >= 0 && c_req[m_own]) m_g = m_own;
            else if (c_req[0] && c_req[1])  m_g = 1 - m_last;
            else if (c_req[0])              m_g = 0;
            else if (c_req[1])              m_g = 1;
        end
    endtask

    task automatic model_check();
        chk("a_gnt", int'(a_if.gnt), int'(m_g == 0));
        chk("b_gnt", int'(b_if.gnt), int'(m_g == 1));
        chk("ram_we", int'(ram_we), (m_g >= 0) ? int'(c_we[m_g]) : 0);
        chk("ram_a", int'(ram_a), (m_g >= 0) ? c_addr[m_g] : 0);
        chk("ram_d", int'(ram_d), (m_g >= 0) ? int'(c_wd[m_g]) : 0);
        chk("a_rvalid", int'(a_if.rvalid), int'(rst_n && m_pend == 0));
        chk("b_rvalid", int'(b_if.rvalid), int'(rst_n && m_pend == 1));
        if (rst_n && m_pend == 0) chk("a_rdata", int'(a_if.rdata), int'(m_pdata));
        if (rst_n && m_pend == 1) chk("b_rdata", int'(b_if.rdata), int'(m_pdata));
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
        end else if (m_g >= 0) begin
            m_last = m_g;
            m_own  = c_lock[m_g] ? m_g : -1;
            if (c_we[m_g]) begin
                shadow[c_addr[m_g]] = c_wd[m_g];
                m_pend = -1;
            end else begin
                m_pend  = m_g;
                m_pdata = shadow[c_addr[m_g]];
            end
        end else begin
            m_own  = -1;
            m_pend = -1;
        end
    endtask

    typedef struct {
        bit       rst;
        bit       ar, aw, al; bit [3:0] aa; bit [7:0] ad;
        bit       br, bw, bl; bit [3:0] ba; bit [7:0] bd;
        bit       eag, ebg, earv, ebrv; bit [7:0] erd;
    } vec_t;

    vec_t tbl [26];

    task automatic drive(input vec_t v);
        rst_n      = !v.rst;
        a_if.req   = v.ar; a_if.we = v.aw; a_if.lock = v.al; a_if.addr = v.aa; a_if.wdata = v.ad;
        b_if.req   = v.br; b_if.we = v.bw; b_if.lock = v.bl; b_if.addr = v.ba; b_if.wdata = v.bd;
    endtask

    // Inputs are already driven (posedge+1); compare at negedge, advance model at posedge
    task automatic run_cycle(input bit use_tbl, input vec_t v, input int row);
        @(negedge clk);
        model_eval();
        model_check();
        if (use_tbl) begin
            chk($sformatf("row%0d a_gnt", row), int'(a_if.gnt), int'(v.eag));
            chk($sformatf("row%0d b_gnt", row), int'(b_if.gnt), int'(v.ebg));
            chk($sformatf("row%0d a_rvalid", row), int'(a_if.rvalid), int'(v.earv));
            chk($sformatf("row%0d b_rvalid", row), int'(b_if.rvalid), int'(v.ebrv));
            if (v.earv) chk($sformatf("row%0d a_rdata", row), int'(a_if.rdata), int'(v.erd));
            if (v.ebrv) chk($sformatf("row%0d b_rdata", row), int'(b_if.rdata), int'(v.erd));
            if (v.rst) chk($sformatf("row%0d ram_we", row), int'(ram_we), 0);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    vec_t idle;
    vec_t cur;
    bit   a_hold, b_hold;

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 8'(i * i);
        idle = '{0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
        //         rst  A: req we lk ad wd   B: req we lk ad wd        exp: ag bg arv brv rd
        tbl[0]  = '{0, 1,0,0,3,0,      0,0,0,0,0,         1,0,0,0,0};
        tbl[1]  = '{0, 0,0,0,0,0,      0,0,0,0,0,         0,0,1,0,9};
        tbl[2]  = '{1, 0,0,0,0,0,      0,0,0,0,0,         0,0,0,0,0};
        tbl[3]  = '{0, 1,0,0,2,0,      1,0,0,5,0,         1,0,0,0,0};
        tbl[4]  = '{0, 1,0,0,2,0,      1,0,0,5,0,         0,1,1,0,4};
        tbl[5]  = '{0, 1,0,0,2,0,      1,0,0,5,0,         1,0,0,1,25};
        tbl[6]  = '{0, 1,0,0,2,0,      1,0,0,5,0,         0,1,1,0,4};
        tbl[7]  = '{0, 0,0,0,0,0,      0,0,0,0,0,         0,0,0,1,25};
        tbl[8]  = '{0, 0,0,0,0,0,      1,1,0,7,8'h73,     0,1,0,0,0};
        tbl[9]  = '{0, 1,0,0,7,0,      0,0,0,0,0,         1,0,0,0,0};
        tbl[10] = '{0, 0,0,0,0,0,      0,0,0,0,0,         0,0,1,0,8'h73};
        tbl[11] = '{0, 0,0,0,0,0,      1,0,0,0,0,         0,1,0,0,0};
        tbl[12] = '{0, 1,0,1,4,0,      1,0,0,0,0,         1,0,0,1,0};
        tbl[13] = '{0, 1,1,0,4,17,     1,0,0,0,0,         1,0,1,0,16};
        tbl[14] = '{0, 0,0,0,0,0,      1,0,0,0,0,         0,1,0,0,0};
        tbl[15] = '{0, 0,0,0,0,0,      0,0,0,0,0,         0,0,0,1,0};
        tbl[16] = '{0, 1,0,0,4,0,      0,0,0,0,0,         1,0,0,0,0};
        tbl[17] = '{0, 0,0,0,0,0,      0,0,0,0,0,         0,0,1,0,17};
        tbl[18] = '{0, 1,0,1,1,0,      0,0,0,0,0,         1,0,0,0,0};
        tbl[19] = '{0, 1,0,1,2,0,      1,0,0,6,0,         1,0,1,0,1};
        tbl[20] = '{0, 0,0,0,0,0,      1,0,0,6,0,         0,1,1,0,4};
        tbl[21] = '{0, 0,0,0,0,0,      0,0,0,0,0,         0,0,0,1,36};
        tbl[22] = '{0, 1,0,0,3,0,      0,0,0,0,0,         1,0,0,0,0};
        tbl[23] = '{1, 1,0,0,3,0,      0,0,0,0,0,         0,0,0,0,0};
        tbl[24] = '{0, 1,0,0,2,0,      1,0,0,5,0,         1,0,0,0,0};
        tbl[25] = '{0, 0,0,0,0,0,      0,0,0,0,0,         0,0,1,0,4};

        drive(idle);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        for (int r = 0; r < 26; r++) begin
            drive(tbl[r]);
            run_cycle(1'b1, tbl[r], r);
        end

        // Randomized traffic: a requester holds its command until granted
        cur = idle;
        for (int n = 0; n < 600; n++) begin
            a_hold = cur.ar && !a_if.gnt && rst_n;
            b_hold = cur.br && !b_if.gnt && rst_n;
            if (!a_hold) begin
                cur.ar = ($urandom_range(3) != 0);
                cur.aw = $urandom_range(1);
                cur.al = ($urandom_range(3) == 0);
                cur.aa = 4'($urandom_range(15));
                cur.ad = 8'($urandom_range(255));
            end
            if (!b_hold) begin
                cur.br = ($urandom_range(3) != 0);
                cur.bw = $urandom_range(1);
                cur.bl = ($urandom_range(3) == 0);
                cur.ba = 4'($urandom_range(15));
                cur.bd = 8'($urandom_range(255));
            end
            cur.rst = ($urandom_range(63) == 0);
            drive(cur);
            run_cycle(1'b0, cur, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_share_arb
`default_nettype wire
